stump_control: RTL and testbench

Stump processor control unit; sits directly upstream of the Stump ALU.
- Holds the instruction register, the condition-code (CC) register and the fetch/execute/memory state machine.
- Decodes each instruction into ALU func, carry-in, operand selects, register-bank and memory strobes.
- Consumes the ALU flags_out to update CC and evaluates branch conditions from CC.

---
 rtl/stump_control_pkg.sv | 53 +++++
 rtl/stump_control_cond_eval.sv | 39 +++
 rtl/stump_control.sv | 139 +++++++++++++
 tb/tb_stump_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stump_control_pkg.sv
// Shared encodings for the Stump control path: states, opcodes, ALU functions,
// branch conditions and NZVC flag positions.
package stump_definitions;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBC = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_MEM = 3'd6,
        OP_BCC = 3'd7
    } opcode_t;

    localparam logic [2:0] FUNC_ADD = 3'd0;
    localparam logic [2:0] FUNC_ADC = 3'd1;
    localparam logic [2:0] FUNC_SUB = 3'd2;
    localparam logic [2:0] FUNC_SBC = 3'd3;
    localparam logic [2:0] FUNC_AND = 3'd4;
    localparam logic [2:0] FUNC_OR  = 3'd5;

    typedef enum logic [3:0] {
        COND_AL = 4'h0, COND_NV = 4'h1, COND_HI = 4'h2, COND_LS = 4'h3,
        COND_CC = 4'h4, COND_CS = 4'h5, COND_NE = 4'h6, COND_EQ = 4'h7,
        COND_VC = 4'h8, COND_VS = 4'h9, COND_PL = 4'hA, COND_MI = 4'hB,
        COND_GE = 4'hC, COND_LT = 4'hD, COND_GT = 4'hE, COND_LE = 4'hF
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam logic [2:0] PC_REG = 3'd7;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/stump_control_cond_eval.sv
// Branch condition evaluator: decides whether a Bcc is taken from the held CC.
module stump_cond_eval
    import stump_definitions::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cc,
    output logic       taken
);

    logic n, z, v, c;

    always_comb begin
        n = cc[FLAG_N];
        z = cc[FLAG_Z];
        v = cc[FLAG_V];
        c = cc[FLAG_C];
        taken = 1'b0;
        case (cond_t'(cond))
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            COND_HI: taken = !c && !z;
            COND_LS: taken = c || z;
            COND_CC: taken = !c;
            COND_CS: taken = c;
            COND_NE: taken = !z;
            COND_EQ: taken = z;
            COND_VC: taken = !v;
            COND_VS: taken = v;
            COND_PL: taken = !n;
            COND_MI: taken = n;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = z || (n != v);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/stump_control.sv
// Stump control unit: instruction/CC registers, fetch-execute-memory sequencer
// and Moore decode of ALU, register-bank and memory controls.
module stump_control
    import stump_definitions::*;
#(
    parameter logic [1:0] RESET_STATE = 2'b00,
    parameter int         DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [3:0]        alu_flags,
    output logic              fetch,
    output logic              execute,
    output logic              memory,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        func,
    output logic              c_in,
    output logic              opB_sel,
    output logic [DATA_W-1:0] imm,
    output logic [2:0]        srcA,
    output logic [2:0]        srcB,
    output logic [1:0]        shift_op,
    output logic              reg_write,
    output logic [2:0]        write_addr,
    output logic              pc_inc,
    output logic              addr_ld,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [3:0]        cc
);

    state_t      state_reg, state_next;
    logic [15:0] ir_reg;
    logic [3:0]  cc_reg;
    logic        cc_load;

    opcode_t     opcode;
    logic        is_imm, s_bit, is_alu, taken;
    logic [2:0]  dst;

    assign opcode = opcode_t'(ir_reg[15:13]);
    assign is_imm = ir_reg[12];
    assign s_bit  = ir_reg[11];
    assign dst    = ir_reg[10:8];
    assign is_alu = (opcode != OP_MEM) && (opcode != OP_BCC);

    stump_cond_eval u_cond_eval (
        .cond  (ir_reg[11:8]),
        .cc    (cc_reg),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= state_t'(RESET_STATE);
            ir_reg    <= '0;
            cc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == FETCH)
                ir_reg <= mem_rdata[15:0];
            if (cc_load)
                cc_reg <= alu_flags;
        end
    end

    always_comb begin
        state_next = FETCH;
        cc_load    = 1'b0;
        func       = FUNC_ADD;
        c_in       = 1'b0;
        opB_sel    = 1'b0;
        imm        = (opcode == OP_BCC) ? sext8(ir_reg[7:0]) : sext5(ir_reg[4:0]);
        srcA       = ir_reg[7:5];
        srcB       = ir_reg[4:2];
        shift_op   = 2'b00;
        reg_write  = 1'b0;
        write_addr = dst;
        pc_inc     = 1'b0;
        addr_ld    = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;

        case (state_reg)
            FETCH: begin
                pc_inc     = 1'b1;
                state_next = EXECUTE;
            end
            EXECUTE: begin
                if (is_alu) begin
                    func      = ir_reg[15:13];
                    opB_sel   = is_imm;
                    c_in      = ((opcode == OP_ADC) || (opcode == OP_SBC)) ? cc_reg[FLAG_C] : 1'b0;
                    shift_op  = is_imm ? 2'b00 : ir_reg[1:0];
                    reg_write = 1'b1;
                    cc_load   = s_bit;
                end else if (opcode == OP_MEM) begin
                    opB_sel    = is_imm;
                    addr_ld    = 1'b1;
                    state_next = MEMORY;
                end else begin
                    // Branch target is PC + offset, computed through the ALU.
                    srcA       = PC_REG;
                    opB_sel    = 1'b1;
                    reg_write  = taken;
                    write_addr = PC_REG;
                end
            end
            MEMORY: begin
                if (s_bit) begin
                    mem_wen = 1'b1;
                    srcA    = dst;
                end else begin
                    mem_ren   = 1'b1;
                    reg_write = 1'b1;
                end
            end
            default: state_next = FETCH;
        endcase

        // Reset wins mid-cycle: suppress every side-effecting strobe.
        if (rst) begin
            cc_load   = 1'b0;
            reg_write = 1'b0;
            pc_inc    = 1'b0;
            addr_ld   = 1'b0;
            mem_ren   = 1'b0;
            mem_wen   = 1'b0;
        end
    end

    assign fetch   = (state_reg == FETCH);
    assign execute = (state_reg == EXECUTE);
    assign memory  = (state_reg == MEMORY);
    assign ir      = ir_reg;
    assign cc      = cc_reg;

endmodule

// File: tb/tb_stump_control.sv
// Directed bench for stump_control: walks reset, ALU, branch and load/store
// sequences and checks decoded controls against hand-computed values.
module tb_stump_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_rdata;
    logic [3:0]  alu_flags;
    logic        fetch, execute, memory;
    logic [15:0] ir;
    logic [2:0]  func;
    logic        c_in, opB_sel;
    logic [15:0] imm;
    logic [2:0]  srcA, srcB;
    logic [1:0]  shift_op;
    logic        reg_write;
    logic [2:0]  write_addr;
    logic        pc_inc, addr_ld, mem_ren, mem_wen;
    logic [3:0]  cc;

    int total = 0;
    int bad   = 0;

    stump_control dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rdata  (mem_rdata),
        .alu_flags  (alu_flags),
        .fetch      (fetch),
        .execute    (execute),
        .memory     (memory),
        .ir         (ir),
        .func       (func),
        .c_in       (c_in),
        .opB_sel    (opB_sel),
        .imm        (imm),
        .srcA       (srcA),
        .srcB       (srcB),
        .shift_op   (shift_op),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .pc_inc     (pc_inc),
        .addr_ld    (addr_ld),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .cc         (cc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run one ALU instruction with S=1 to load cc with the given flags.
    task automatic set_cc(input logic [3:0] flags);
        mem_rdata = 16'h0800;
        tick();
        alu_flags = flags;
        tick();
        chk("set_cc", {12'h0, cc}, {12'h0, flags});
    endtask

    // Fetch and execute one branch, checking the taken decision.
    task automatic branch(input string tag, input logic [15:0] instr, input logic exp_taken);
        mem_rdata = instr;
        tick();
        alu_flags = 4'hF;
        chk(tag, {15'h0, reg_write}, {15'h0, exp_taken});
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        mem_rdata = 16'h0000;
        alu_flags = 4'h0;

        // 1. reset state
        tick();
        tick();
        chk("rst_fetch", {15'h0, fetch}, 16'h1);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_cc", {12'h0, cc}, 16'h0);
        chk("rst_pc_inc", {15'h0, pc_inc}, 16'h0);
        chk("rst_reg_write", {15'h0, reg_write}, 16'h0);
        rst = 1'b0;
        #1;
        chk("fetch_pc_inc", {15'h0, pc_inc}, 16'h1);
        chk("fetch_strobes", {12'h0, reg_write, addr_ld, mem_ren, mem_wen}, 16'h0);
        chk("fetch_func", {13'h0, func}, 16'h0);
        tick();
        chk("nop_execute", {13'h0, fetch, execute, memory}, 16'b010);
        tick();
        chk("nop_back_fetch", {13'h0, fetch, execute, memory}, 16'b100);

        // 2. ADD S R2,R1,R3
        mem_rdata = 16'h0A2C;
        tick();
        alu_flags = 4'b0110;
        chk("add_ir", ir, 16'h0A2C);
        chk("add_func", {13'h0, func}, 16'h0);
        chk("add_srcA", {13'h0, srcA}, 16'h1);
        chk("add_srcB", {13'h0, srcB}, 16'h3);
        chk("add_waddr", {13'h0, write_addr}, 16'h2);
        chk("add_wen", {15'h0, reg_write}, 16'h1);
        chk("add_opB_sel", {15'h0, opB_sel}, 16'h0);
        chk("add_cc_not_yet", {12'h0, cc}, 16'h0);
        tick();
        chk("add_cc", {12'h0, cc}, 16'h6);
        chk("add_fetch", {15'h0, fetch}, 16'h1);

        // 3. ADD R1,R0,#-1 (no S)
        mem_rdata = 16'h111F;
        tick();
        alu_flags = 4'hF;
        chk("addi_imm", imm, 16'hFFFF);
        chk("addi_opB_sel", {15'h0, opB_sel}, 16'h1);
        chk("addi_shift", {14'h0, shift_op}, 16'h0);
        chk("addi_waddr", {13'h0, write_addr}, 16'h1);
        tick();
        chk("addi_cc_kept", {12'h0, cc}, 16'h6);

        // SBC S to R7 still updates cc
        mem_rdata = 16'h6F00;
        tick();
        alu_flags = 4'b0101;
        chk("sbc_func", {13'h0, func}, 16'h3);
        chk("sbc_c_in", {15'h0, c_in}, 16'h0);
        chk("sbc_waddr", {13'h0, write_addr}, 16'h7);
        tick();
        chk("sbc_r7_cc", {12'h0, cc}, 16'h5);

        // ADC uses carry from cc
        mem_rdata = 16'h2000;
        tick();
        chk("adc_func", {13'h0, func}, 16'h1);
        chk("adc_c_in", {15'h0, c_in}, 16'h1);
        tick();

        // 4. BEQ -2 with Z set, then clear
        set_cc(4'h4);
        mem_rdata = 16'hE7FE;
        tick();
        alu_flags = 4'hF;
        chk("beq_wen", {15'h0, reg_write}, 16'h1);
        chk("beq_waddr", {13'h0, write_addr}, 16'h7);
        chk("beq_imm", imm, 16'hFFFE);
        chk("beq_srcA", {13'h0, srcA}, 16'h7);
        chk("beq_opB_sel", {15'h0, opB_sel}, 16'h1);
        chk("beq_func_cin", {12'h0, func, c_in}, 16'h0);
        tick();
        chk("beq_cc_kept", {12'h0, cc}, 16'h4);
        chk("beq_fetch", {15'h0, fetch}, 16'h1);
        set_cc(4'h0);
        branch("beq_not_taken", 16'hE7FE, 1'b0);

        // condition table with N=1, V=1, Z=0, C=0
        set_cc(4'b1010);
        branch("b_al", 16'hE0FE, 1'b1);
        branch("b_nv", 16'hE1FE, 1'b0);
        branch("b_hi", 16'hE2FE, 1'b1);
        branch("b_cs", 16'hE5FE, 1'b0);
        branch("b_ge", 16'hECFE, 1'b1);
        branch("b_lt", 16'hEDFE, 1'b0);
        branch("b_gt", 16'hEEFE, 1'b1);
        branch("b_le", 16'hEFFE, 1'b0);

        // 5. LD R3,[R4,R5]
        mem_rdata = 16'hC394;
        tick();
        chk("ld_exec_state", {13'h0, fetch, execute, memory}, 16'b010);
        chk("ld_addr_ld", {15'h0, addr_ld}, 16'h1);
        chk("ld_srcA", {13'h0, srcA}, 16'h4);
        chk("ld_srcB", {13'h0, srcB}, 16'h5);
        chk("ld_exec_wen", {15'h0, reg_write}, 16'h0);
        tick();
        chk("ld_mem_state", {15'h0, memory}, 16'h1);
        chk("ld_mem_ren", {15'h0, mem_ren}, 16'h1);
        chk("ld_mem_wen_reg", {15'h0, reg_write}, 16'h1);
        chk("ld_waddr", {13'h0, write_addr}, 16'h3);
        chk("ld_no_store", {14'h0, mem_wen, addr_ld}, 16'h0);
        tick();
        chk("ld_done_fetch", {15'h0, fetch}, 16'h1);

        // ST R3,[R4,R5]
        mem_rdata = 16'hCB94;
        tick();
        chk("st_addr_ld", {15'h0, addr_ld}, 16'h1);
        tick();
        chk("st_mem_wen", {15'h0, mem_wen}, 16'h1);
        chk("st_srcA", {13'h0, srcA}, 16'h3);
        chk("st_reg_write", {15'h0, reg_write}, 16'h0);
        chk("st_mem_ren", {15'h0, mem_ren}, 16'h0);
        tick();
        chk("st_done_fetch", {15'h0, fetch}, 16'h1);

        // 6. reset during MEMORY of a load
        set_cc(4'hF);
        mem_rdata = 16'hC394;
        tick();
        tick();
        chk("rstmem_in_memory", {15'h0, memory}, 16'h1);
        rst = 1'b1;
        #1;
        chk("rstmem_ren", {15'h0, mem_ren}, 16'h0);
        chk("rstmem_wen", {15'h0, reg_write}, 16'h0);
        tick();
        chk("rstmem_fetch", {15'h0, fetch}, 16'h1);
        chk("rstmem_cc", {12'h0, cc}, 16'h0);
        chk("rstmem_ir", ir, 16'h0000);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
